// File: rtl/mm_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mm_controller_if                                                 |
// | Brief   : Handshake, memory-address and datapath-control bundle for the    |
// |           matrix-multiply sequencer.                                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface mm_controller_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH-1:0] addr_A;
  logic [ADDR_WIDTH-1:0] addr_B;
  logic [ADDR_WIDTH-1:0] addr_C;
  logic                  we_C;
  logic                  en_Mux;
  logic                  en_PPReg;
  logic                  en_FDReg;
  logic                  resultIsInvalid;

  modport master (
    input  start, resultIsInvalid,
    output busy, done, error, addr_A, addr_B, addr_C,
           we_C, en_Mux, en_PPReg, en_FDReg
  );

  modport slave (
    output start, resultIsInvalid,
    input  busy, done, error, addr_A, addr_B, addr_C,
           we_C, en_Mux, en_PPReg, en_FDReg
  );
endinterface
`default_nettype wire

// File: rtl/mm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mm_controller                                                    |
// | Brief   : Sequencer for C = A x B on N x N row-major matrices; optional    |
// |           early abort on an invalid result via MMCTRL_ERR_ABORT_EN.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mm_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  mm_controller_if.master bus
);
  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);

  generate
    if (N < 2 || N > 16 || ADDR_WIDTH < $clog2(N * N) || DATA_WIDTH < 1) begin : g_bad_params
      $error("mm_controller: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_i, r_j, r_k, w_i_n, w_j_n, w_k_n;
  logic                  r_error, w_error_n;
  logic                  r_busy, r_done, r_we_C, r_en_Mux, r_en_PPReg, r_en_FDReg;
  logic [ADDR_WIDTH-1:0] r_addr_A, r_addr_B, r_addr_C;
  logic [ADDR_WIDTH-1:0] w_addr_A_n, w_addr_B_n, w_addr_C_n;

  always_comb begin
    w_state_n = r_state;
    w_i_n     = r_i;
    w_j_n     = r_j;
    w_k_n     = r_k;
    w_error_n = r_error;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_n = S_ISSUE;
          w_i_n     = '0;
          w_j_n     = '0;
          w_k_n     = '0;
          w_error_n = 1'b0;
        end
      end
      S_ISSUE: begin
        if (r_k == c_LAST) begin
          w_state_n = S_DRAIN;
          w_k_n     = '0;
        end else begin
          w_k_n = r_k + CW'(1);
        end
      end
      S_DRAIN: w_state_n = S_FINAL;
      S_FINAL: w_state_n = S_WRITE;
      S_WRITE: begin
        if (bus.resultIsInvalid) w_error_n = 1'b1;
`ifdef MMCTRL_ERR_ABORT_EN
        if (bus.resultIsInvalid || (r_i == c_LAST && r_j == c_LAST)) begin
`else
        if (r_i == c_LAST && r_j == c_LAST) begin
`endif
          w_state_n = S_DONE;
          w_i_n     = '0;
          w_j_n     = '0;
        end else begin
          w_state_n = S_ISSUE;
          if (r_j == c_LAST) begin
            w_j_n = '0;
            w_i_n = r_i + CW'(1);
          end else begin
            w_j_n = r_j + CW'(1);
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so the registered copy lines up with it.
    w_addr_A_n = '0;
    w_addr_B_n = '0;
    w_addr_C_n = '0;
    if (w_state_n == S_ISSUE) begin
      w_addr_A_n = ADDR_WIDTH'(w_i_n) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_k_n);
      w_addr_B_n = ADDR_WIDTH'(w_k_n) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_j_n);
    end
    if (w_state_n == S_WRITE) begin
      w_addr_C_n = ADDR_WIDTH'(w_i_n) * ADDR_WIDTH'(N) + ADDR_WIDTH'(w_j_n);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_we_C     <= 1'b0;
      r_en_Mux   <= 1'b0;
      r_en_PPReg <= 1'b0;
      r_en_FDReg <= 1'b0;
      r_addr_A   <= '0;
      r_addr_B   <= '0;
      r_addr_C   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_i        <= w_i_n;
      r_j        <= w_j_n;
      r_k        <= w_k_n;
      r_error    <= w_error_n;
      r_busy     <= (w_state_n != S_IDLE);
      r_done     <= (w_state_n == S_DONE);
      r_we_C     <= (w_state_n == S_WRITE);
      // Partial-product enables trail each ISSUE cycle by one; k=0 restarts accumulation.
      r_en_PPReg <= (r_state == S_ISSUE);
      r_en_Mux   <= (r_state == S_ISSUE) && (r_k != '0);
      r_en_FDReg <= (w_state_n == S_FINAL);
      r_addr_A   <= w_addr_A_n;
      r_addr_B   <= w_addr_B_n;
      r_addr_C   <= w_addr_C_n;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
  assign bus.addr_A   = r_addr_A;
  assign bus.addr_B   = r_addr_B;
  assign bus.addr_C   = r_addr_C;
  assign bus.en_Mux   = r_en_Mux;
  assign bus.en_PPReg = r_en_PPReg;
  assign bus.en_FDReg = r_en_FDReg;
`ifdef MMCTRL_ERR_ABORT_EN
  // The invalid flag only arrives during WRITE, so the write strobe is gated combinationally.
  assign bus.we_C     = r_we_C & ~bus.resultIsInvalid;
`else
  assign bus.we_C     = r_we_C;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mm_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mm_controller                                                 |
// | Brief   : Self-checking bench for mm_controller (N=2) using a timeline     |
// |           model of each run built from element order and cycle budget.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mm_controller;
  localparam int N    = 2;
  localparam int AW   = 4;
  localparam int NN   = N * N;
  localparam int EL   = N + 3;
  localparam int MAXC = 64;

  typedef struct {
    logic busy, done, err, we, mux, pp, fd, ab_v, ac_v;
    logic [AW-1:0] aA, aB, aC;
  } exp_t;

  typedef struct {
    logic start;
    exp_t e;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic prev_err;
  exp_t exp_arr [MAXC];
  int   wr_el   [MAXC];
  int   exp_len;

  mm_controller_if #(.ADDR_WIDTH(AW)) bus ();

  mm_controller #(.DATA_WIDTH(8), .N(N), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic busy, done, we, mux, pp, fd, ab_v,
                              input int aA, aB, input logic ac_v, input int aC);
    exp_t x;
    x.busy = busy; x.done = done; x.err = 1'b0; x.we = we;
    x.mux = mux; x.pp = pp; x.fd = fd;
    x.ab_v = ab_v; x.aA = AW'(aA); x.aB = AW'(aB);
    x.ac_v = ac_v; x.aC = AW'(aC);
    return x;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h required %0h", nm, c, act, expv);
    end
  endtask

  task automatic check_cycle(input int c, input exp_t x);
    chk("busy",     c, 32'(bus.busy),     32'(x.busy));
    chk("done",     c, 32'(bus.done),     32'(x.done));
    chk("error",    c, 32'(bus.error),    32'(x.err));
    chk("we_C",     c, 32'(bus.we_C),     32'(x.we));
    chk("en_Mux",   c, 32'(bus.en_Mux),   32'(x.mux));
    chk("en_PPReg", c, 32'(bus.en_PPReg), 32'(x.pp));
    chk("en_FDReg", c, 32'(bus.en_FDReg), 32'(x.fd));
    if (x.ab_v) begin
      chk("addr_A", c, 32'(bus.addr_A), 32'(x.aA));
      chk("addr_B", c, 32'(bus.addr_B), 32'(x.aB));
    end
    if (x.ac_v) chk("addr_C", c, 32'(bus.addr_C), 32'(x.aC));
  endtask

  // Timeline of one run, cycle 0 = first ISSUE cycle; element e occupies cycles e*EL .. e*EL+EL-1.
  task automatic build_run(input logic inv_el [NN]);
    int  done_c, err_c, b, i, j, w;
    bit  aborted;
    for (int c = 0; c < MAXC; c++) begin
      exp_arr[c] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      wr_el[c]   = 0;
    end
    done_c  = NN * EL;
    err_c   = MAXC;
    aborted = 0;
    for (int e = 0; e < NN; e++) begin
      if (!aborted) begin
        b = e * EL; i = e / N; j = e % N;
        for (int k = 0; k < N; k++) begin
          exp_arr[b+k].ab_v = 1'b1;
          exp_arr[b+k].aA   = AW'(i * N + k);
          exp_arr[b+k].aB   = AW'(k * N + j);
          exp_arr[b+k+1].pp = 1'b1;
          exp_arr[b+k+1].mux = (k != 0);
        end
        exp_arr[b+N+1].fd = 1'b1;
        w = b + N + 2;
        exp_arr[w].we   = 1'b1;
        exp_arr[w].ac_v = 1'b1;
        exp_arr[w].aC   = AW'(e);
        wr_el[w]        = e + 1;
        if (inv_el[e]) begin
          if (err_c == MAXC) err_c = w + 1;
`ifdef MMCTRL_ERR_ABORT_EN
          exp_arr[w].we   = 1'b0;
          exp_arr[w].ac_v = 1'b0;
          done_c  = w + 1;
          aborted = 1;
`endif
        end
      end
    end
    for (int c = 0; c <= done_c; c++) exp_arr[c].busy = 1'b1;
    exp_arr[done_c].done = 1'b1;
    for (int c = err_c; c <= done_c + 1; c++) exp_arr[c].err = 1'b1;
    exp_len = done_c + 2;
  endtask

  // smode: 0 = start only to launch, 1 = random start during run, 2 = start held high.
  task automatic run_checked(input logic inv_el [NN], input int smode, input bit noise);
    exp_t idle;
    build_run(inv_el);
    @(negedge clk);
    bus.start           = 1'b1;
    bus.resultIsInvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle.err = prev_err;
    check_cycle(-1, idle);
    for (int c = 0; c < exp_len; c++) begin
      @(negedge clk);
      if (c == exp_len - 1)  bus.start = 1'b0;
      else if (smode == 2)   bus.start = 1'b1;
      else if (smode == 1)   bus.start = 1'($urandom_range(0, 1));
      else                   bus.start = 1'b0;
      if (wr_el[c] != 0)     bus.resultIsInvalid = inv_el[wr_el[c]-1];
      else                   bus.resultIsInvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check_cycle(c, exp_arr[c]);
    end
    prev_err = exp_arr[exp_len-1].err;
  endtask

  initial begin
    vec_t vecs [8];
    exp_t zero_rec;
    logic inv_set [NN];

    n_cmp = 0;
    n_err = 0;
    prev_err = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.resultIsInvalid = 1'b0;
    zero_rec = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);

    // Opening cycles of an N=2 run, row 0 is the IDLE cycle that carries start.
    vecs[0] = '{1'b1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0)};
    vecs[1] = '{1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
    vecs[2] = '{1'b0, mk(1, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0)};
    vecs[3] = '{1'b0, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    vecs[4] = '{1'b0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[5] = '{1'b0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[6] = '{1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
    vecs[7] = '{1'b0, mk(1, 0, 0, 0, 1, 0, 1, 1, 3, 0, 0)};

    repeat (2) @(negedge clk);
    #1 check_cycle(-1, zero_rec);
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      bus.start = vecs[r].start;
      bus.resultIsInvalid = 1'b0;
      #1 check_cycle(r, vecs[r].e);
    end

    // Advance into the first ISSUE cycle of element (1,0), then reset asynchronously.
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1 check_cycle(11, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    #1 reset = 1'b1;
    #1 check_cycle(-2, zero_rec);
    @(negedge clk);
    #1 check_cycle(-3, zero_rec);
    reset = 1'b0;
    @(negedge clk);
    #1 check_cycle(-4, zero_rec);
    prev_err = 1'b0;

    for (int e = 0; e < NN; e++) inv_set[e] = 1'b0;
    run_checked(inv_set, 0, 1'b0);
    run_checked(inv_set, 2, 1'b0);
    inv_set[1] = 1'b1;
    run_checked(inv_set, 0, 1'b0);
    inv_set[1] = 1'b0;
    run_checked(inv_set, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      for (int e = 0; e < NN; e++) inv_set[e] = ($urandom_range(0, 3) == 0);
      run_checked(inv_set, int'($urandom_range(0, 2)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mm_controller.md
MM_CONTROLLER -- requirements
Module: mm_controller

Interface
REQ-001 Parameter: DATA_WIDTH, 8, datapath data width; the controller does not use it internally.
REQ-002 Parameter: N, 4, square matrix dimension; legal range 2..16.
REQ-003 Parameter: ADDR_WIDTH, 4, memory address width; must be >= clog2(N*N).
REQ-004 Port: clk  in  1  single clock; rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle pulse; begins C = A x B.
REQ-007 Port: busy  out  1  run in progress.
REQ-008 Port: done  out  1  one-cycle completion pulse.
REQ-009 Port: error  out  1  sticky: an invalid result was seen this run.
REQ-010 Port: addr_A, addr_B  out  ADDR_WIDTH  synchronous-read addresses; 1-cycle read latency.
REQ-011 Port: addr_C  out  ADDR_WIDTH  write address for C.
REQ-012 Port: we_C  out  1  write enable for C.
REQ-013 Port: en_Mux, en_PPReg, en_FDReg  out  1  each  datapath controls.
REQ-014 Port: resultIsInvalid  in  1  datapath overflow/invalid flag for the current result.

Function
REQ-015 All outputs shall be registered.
REQ-016 FSM states: IDLE, ISSUE, DRAIN, FINAL, WRITE, DONE.
REQ-017 Storage: all matrices row-major; element (i,j) is computed in order j fastest, then i.
REQ-018 IDLE with start=1 -> ISSUE with i=j=k=0; error cleared in the same cycle.
REQ-019 start outside IDLE shall be ignored.
REQ-020 ISSUE: addr_A=i*N+k, addr_B=k*N+j; k increments each cycle; after k=N-1 -> DRAIN.
REQ-021 The cycle after each ISSUE cycle: en_PPReg=1; en_Mux=0 if that ISSUE had k=0, else 1.
REQ-022 DRAIN: carries only the delayed en_PPReg/en_Mux of the last ISSUE; -> FINAL.
REQ-023 FINAL: en_FDReg=1; -> WRITE.
REQ-024 WRITE: we_C=1, addr_C=i*N+j; resultIsInvalid is sampled in this cycle.
REQ-025 WRITE exit: j increments; j wraps to 0 with i incrementing; after i=j=N-1 -> DONE, else -> ISSUE with k=0.
REQ-026 Timing: each element takes N+3 cycles; a full run is N*N*(N+3) cycles from ISSUE entry to DONE.
REQ-027 DONE: done=1 for one cycle; -> IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 en_*, we_C shall be 0 in any cycle not listed above.
REQ-030 Address arithmetic shall be unsigned, truncated to ADDR_WIDTH.
REQ-031 resultIsInvalid in a WRITE cycle sets error; error holds until the next accepted start or reset.

Reset
REQ-032 reset=1 shall force IDLE immediately, regardless of clk.
REQ-033 On reset, all outputs and the i, j, k counters shall be 0.
REQ-034 Reset mid-run abandons the run; no done pulse; no further we_C.
REQ-035 After reset deasserts, the next start begins a fresh run from element (0,0).

Configuration
REQ-036 Macro MMCTRL_ERR_ABORT_EN.
REQ-037 Defined: resultIsInvalid=1 in WRITE suppresses we_C for that cycle and goes directly to DONE, with error=1 and done=1.
REQ-038 Undefined: we_C is asserted normally, the run completes all N*N elements, and error is set per REQ-031.

Verification
REQ-039 N=2, start at cycle 0 -> busy from cycle 1; addr_A/addr_B sequence 0/0, 1/2; we_C at addr 0 in cycle 5; done 20 cycles after ISSUE entry.
REQ-040 N=2 full run -> we_C addresses 0,1,2,3 exactly once each; en_Mux=0 exactly once per element; en_FDReg exactly 4 times.
REQ-041 start held high for the whole run -> exactly one run; done pulses once; a new start after IDLE begins another run.
REQ-042 reset asserted mid-ISSUE of element (1,0) -> all outputs 0 immediately, no done; the next start restarts at addr_A=0.
REQ-043 resultIsInvalid=1 during the WRITE of element (0,1):
- macro defined -> no we_C at addr 1; done next cycle; error=1.
- macro undefined -> all 4 writes occur; error=1 until the next start.
